logicnet_lut_neuron: RTL and testbench

LOGICNET_LUT_NEURON -- requirements
Module: logicnet_lut_neuron

---
 rtl/logicnet_lut_neuron.sv | 121 ++++++++++++
 tb/tb_logicnet_lut_neuron.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/logicnet_lut_neuron.sv
// LogicNet LUT neuron: a loadable DEPTH x OUT_BITS truth table indexed by the
// concatenated neuron inputs, with a one-deep valid/ready output stage.
module logicnet_lut_neuron #(
  parameter int FAN_IN   = 3,
  parameter int IN_BITS  = 2,
  parameter int OUT_BITS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_start,
  input  logic                        cfg_valid,
  input  logic [OUT_BITS-1:0]         cfg_data,
  output logic                        cfg_done,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [FAN_IN*IN_BITS-1:0]   in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_BITS-1:0]         out_data,
  output logic [1:0]                  state_o
);

  localparam int AW    = FAN_IN * IN_BITS;
  localparam int DEPTH = 1 << AW;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_LOAD  = 2'b01;
  localparam logic [1:0] ST_RUN   = 2'b10;

  // Truth table; deliberately has no reset so contents survive rst.
  logic [OUT_BITS-1:0] lut_q [DEPTH];

  logic [1:0]          state_q,     state_d;
  logic [AW-1:0]       wptr_q,      wptr_d;
  logic                out_valid_q, out_valid_d;
  logic [OUT_BITS-1:0] out_data_q,  out_data_d;
  logic                cfg_done_q,  cfg_done_d;
  logic                lut_we;
  logic                in_accept;

  // Input is accepted only while running, the output slot is free or draining,
  // and no reload request is pending; reset forces it low.
  assign in_ready  = !rst && (state_q == ST_RUN) &&
                     (!out_valid_q || out_ready) && !cfg_start;
  assign in_accept = in_valid && in_ready;

  assign cfg_done  = cfg_done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign state_o   = state_q;

  // Next-state logic for the load/run controller and the output stage.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    cfg_done_d  = 1'b0;
    lut_we      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (cfg_start) begin
          state_d = ST_LOAD;
          wptr_d  = '0;
        end
      end
      ST_LOAD: begin
        if (cfg_start) begin
          wptr_d = '0;
        end else if (cfg_valid) begin
          lut_we = 1'b1;
          wptr_d = wptr_q + 1'b1;
          if (wptr_q == '1) begin
            cfg_done_d = 1'b1;
            state_d    = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (cfg_start) begin
          state_d     = ST_LOAD;
          wptr_d      = '0;
          out_valid_d = 1'b0;
        end else if (in_accept) begin
          out_valid_d = 1'b1;
          out_data_d  = lut_q[in_data];
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      wptr_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cfg_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cfg_done_q  <= cfg_done_d;
    end
  end

  // Table write port; reset blocks writes but never clears entries.
  always_ff @(posedge clk) begin
    if (lut_we && !rst) begin
      lut_q[wptr_q] <= cfg_data;
    end
  end

endmodule

// File: tb/tb_logicnet_lut_neuron.sv
// Self-checking bench for logicnet_lut_neuron: directed scenarios plus random
// streams, compared against a transaction-level model of table and output slot.
module tb_logicnet_lut_neuron;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_start = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_data = '0;
  logic       cfg_done;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] out_data;
  logic [1:0] state_o;

  int n_vec = 0;
  int n_err = 0;
  int done_seen = 0;

  // Reference model: mode 0 EMPTY, 1 LOAD, 2 RUN; table image; output slot.
  int m_mode = 0;
  int m_wcount = 0;
  int m_tab [64];
  int m_ov = 0;
  int m_od = 0;
  int m_done = 0;

  logic_wrap_dummy_unused_guard: assert property (@(posedge clk) 1'b1);

  always #5 clk = ~clk;

  logicnet_lut_neuron #(.FAN_IN(3), .IN_BITS(2), .OUT_BITS(2)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_data(cfg_data), .cfg_done(cfg_done), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .state_o(state_o)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step(input bit rdy);
    m_done = 0;
    if (rst) begin
      m_mode = 0; m_wcount = 0; m_ov = 0; m_od = 0;
    end else if (m_mode == 0) begin
      if (cfg_start) begin m_mode = 1; m_wcount = 0; end
    end else if (m_mode == 1) begin
      if (cfg_start) m_wcount = 0;
      else if (cfg_valid) begin
        m_tab[m_wcount] = int'(cfg_data);
        m_wcount++;
        if (m_wcount == 64) begin m_done = 1; m_mode = 2; m_wcount = 0; end
      end
    end else begin
      if (cfg_start) begin m_mode = 1; m_wcount = 0; m_ov = 0; end
      else if (in_valid && rdy) begin m_ov = 1; m_od = m_tab[int'(in_data)]; end
      else if (out_ready) m_ov = 0;
    end
  endtask

  // One clock: check the combinational ready, clock, then check registered outputs.
  task automatic tick(input string tag);
    bit exp_rdy;
    #1;
    exp_rdy = !rst && (m_mode == 2) && (m_ov == 0 || out_ready) && !cfg_start;
    chk({tag, ".in_ready"}, int'(in_ready), int'(exp_rdy));
    model_step(exp_rdy);
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, int'(out_valid), m_ov);
    chk({tag, ".out_data"}, int'(out_data), m_od);
    chk({tag, ".state"}, int'(state_o), m_mode);
    chk({tag, ".cfg_done"}, int'(cfg_done), m_done);
    if (cfg_done) done_seen++;
  endtask

  task automatic load_table(input bit gaps, input bit seq, input string tag);
    done_seen = 0;
    cfg_start = 1'b1;
    tick({tag, ".start"});
    cfg_start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (gaps) begin cfg_valid = 1'b0; tick({tag, ".gap"}); end
      cfg_valid = 1'b1;
      cfg_data  = seq ? 2'(i & 3) : 2'($urandom_range(0, 3));
      tick({tag, ".wr"});
    end
    cfg_valid = 1'b0;
    chk({tag, ".done_after_last"}, int'(cfg_done), 1);
    chk({tag, ".done_count"}, done_seen, 1);
    chk({tag, ".run_state"}, int'(state_o), 2);
  endtask

  task automatic rand_run(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = 6'($urandom_range(0, 63));
      tick("rand");
    end
  endtask

  initial begin
    // Reset state.
    rst = 1'b1;
    tick("rst");
    tick("rst");
    chk("rst.out_valid", int'(out_valid), 0);
    chk("rst.out_data", int'(out_data), 0);
    chk("rst.state", int'(state_o), 0);
    rst = 1'b0;
    tick("idle");

    // Sequential load: entry i = i[1:0].
    load_table(1'b0, 1'b1, "load_seq");

    // Stream every index back-to-back; result arrives one cycle later.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_data = 6'(i);
      tick("stream");
      chk("stream.val", int'(out_valid), 1);
      chk("stream.lut", int'(out_data), i & 3);
    end
    in_valid = 1'b0;
    tick("drain");
    chk("drain.out_valid", int'(out_valid), 0);

    // Backpressure with index 32 pending.
    in_valid = 1'b1; in_data = 6'b100000; out_ready = 1'b1;
    tick("bp.first");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick("bp.hold");
      chk("bp.hold_data", int'(out_data), 0);
      chk("bp.hold_valid", int'(out_valid), 1);
    end
    out_ready = 1'b1; in_data = 6'd33;
    tick("bp.release");
    chk("bp.release_data", int'(out_data), 1);

    rand_run(200);

    // Gapped reload of random data, restarted after 30 writes.
    in_valid = 1'b0; out_ready = 1'b1;
    done_seen = 0;
    cfg_start = 1'b1;
    tick("gap.start");
    cfg_start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cfg_valid = 1'b0; tick("gap.idle");
      cfg_valid = 1'b1; cfg_data = 2'($urandom_range(0, 3)); tick("gap.wr");
    end
    cfg_valid = 1'b0;
    chk("gap.no_early_done", done_seen, 0);
    cfg_start = 1'b1;
    tick("gap.restart");
    cfg_start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      cfg_valid = 1'b0; tick("gap.idle2");
      if (i == 63) chk("gap.still_load", int'(state_o), 1);
      cfg_valid = 1'b1; cfg_data = 2'($urandom_range(0, 3)); tick("gap.wr2");
    end
    cfg_valid = 1'b0;
    chk("gap.done_count", done_seen, 1);
    chk("gap.run", int'(state_o), 2);
    rand_run(200);

    // cfg_start while running with an input offered.
    in_valid = 1'b1; out_ready = 1'b1; in_data = 6'd5;
    tick("cs.prime");
    cfg_start = 1'b1;
    tick("cs.req");
    cfg_start = 1'b0;
    chk("cs.out_valid", int'(out_valid), 0);
    chk("cs.state", int'(state_o), 1);
    in_valid = 1'b0;

    // Reload, stream, then reset mid-stream.
    rst = 1'b1; tick("pre.rst"); rst = 1'b0;
    load_table(1'b0, 1'b0, "load_rnd");
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 6'($urandom_range(0, 63));
      tick("mid.stream");
    end
    rst = 1'b1;
    tick("mid.rst");
    rst = 1'b0;
    chk("mid.out_valid", int'(out_valid), 0);
    chk("mid.state", int'(state_o), 0);
    for (int i = 0; i < 4; i++) tick("mid.ignored");
    cfg_start = 1'b1; tick("mid.cfg"); cfg_start = 1'b0;
    cfg_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cfg_data = 2'($urandom_range(0, 3));
      tick("mid.partial");
    end
    cfg_valid = 1'b0; in_valid = 1'b0;
    chk("mid.still_load", int'(state_o), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
